// File: rtl/encoder_83_pkg.sv
// Shared widths, reset values and result bundle
// for the registered 8-to-3 priority encoder.
package encoder_83_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 3;

  localparam logic [OUT_W-1:0] OUT_RST   = '0;
  localparam logic             VALID_RST = 1'b0;
  localparam logic             MULTI_RST = 1'b0;

  typedef struct packed {
    logic [OUT_W-1:0] idx;
    logic             valid;
    logic             multi;
  } enc_t;

  localparam enc_t ENC_RST = '{
    idx:   OUT_RST,
    valid: VALID_RST,
    multi: MULTI_RST
  };

endpackage

// File: rtl/encoder_83_core.sv
// Combinational highest-set-bit encoder with
// any-set and two-or-more-set flags.
module encoder_83_core
  import encoder_83_pkg::*;
(
  input  logic [IN_W-1:0] data_in,
  output enc_t            enc
);

  always_comb begin
    enc = ENC_RST;
    // Highest-numbered bit wins on multi-hot input
    priority case (1'b1)
      data_in[7]: enc.idx = 3'd7;
      data_in[6]: enc.idx = 3'd6;
      data_in[5]: enc.idx = 3'd5;
      data_in[4]: enc.idx = 3'd4;
      data_in[3]: enc.idx = 3'd3;
      data_in[2]: enc.idx = 3'd2;
      data_in[1]: enc.idx = 3'd1;
      data_in[0]: enc.idx = 3'd0;
      default:    enc.idx = OUT_RST;
    endcase
    enc.valid = |data_in;
    // Clearing the lowest set bit leaves a residue
    // only when two or more bits were set
    enc.multi = |(data_in & (data_in - 8'd1));
  end

endmodule

// File: rtl/encoder_83.sv
// Registered 8-to-3 priority encoder top:
// core plus a synchronous-reset output register.
module encoder_83
  import encoder_83_pkg::*;
(
  output logic [OUT_W-1:0] out,
  input  logic [IN_W-1:0]  data_in,
  input  logic             clk,
  input  logic             rst,
  output logic             valid,
  output logic             multi
);

  enc_t enc_d;
  enc_t enc_q;

  encoder_83_core u_core (
    .data_in (data_in),
    .enc     (enc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) enc_q <= ENC_RST;
    else     enc_q <= enc_d;
  end

  assign out   = enc_q.idx;
  assign valid = enc_q.valid;
  assign multi = enc_q.multi;

endmodule

// File: tb/tb_encoder_83.sv
// Self-checking bench for encoder_83: directed
// cases plus random vectors against a reference.
module tb_encoder_83;

  logic [2:0] out;
  logic [7:0] data_in;
  logic       clk;
  logic       rst;
  logic       valid;
  logic       multi;

  int checks;
  int passes;

  encoder_83 dut (
    .out     (out),
    .data_in (data_in),
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .multi   (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    checks++;
    if (got === exp) passes++;
    else
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int ref_idx(input logic [7:0] d);
    int hi = 0;
    for (int i = 0; i < 8; i++)
      if (d[i]) hi = i;
    return hi;
  endfunction

  task automatic step(
    input logic [7:0] d,
    input logic       r,
    input string      tag
  );
    logic [7:0] e_out;
    logic [7:0] e_val;
    logic [7:0] e_mul;
    @(negedge clk);
    data_in = d;
    rst     = r;
    @(posedge clk);
    #1;
    if (r) begin
      e_out = 0; e_val = 0; e_mul = 0;
    end else begin
      e_out = 8'(ref_idx(d));
      e_val = {7'd0, d != 8'd0};
      e_mul = {7'd0, $countones(d) >= 2};
    end
    chk({tag, ".out"},   {5'd0, out},   e_out);
    chk({tag, ".valid"}, {7'd0, valid}, e_val);
    chk({tag, ".multi"}, {7'd0, multi}, e_mul);
  endtask

  initial begin
    logic [7:0] v;
    logic       r;
    checks  = 0;
    passes  = 0;
    rst     = 1'b1;
    data_in = 8'hFF;

    step(8'hFF, 1'b1, "rst0");
    step(8'hFF, 1'b1, "rst1");

    for (int i = 0; i < 8; i++)
      step(8'(1 << i), 1'b0, $sformatf("onehot%0d", i));

    step(8'h12, 1'b0, "mh12");
    step(8'h21, 1'b0, "mh21");
    step(8'hFF, 1'b0, "mhFF");

    step(8'h80, 1'b0, "pre_zero");
    step(8'h00, 1'b0, "zero");

    step(8'h40, 1'b0, "s40a");
    step(8'h40, 1'b1, "s40rst");
    step(8'h40, 1'b0, "s40b");

    for (int n = 0; n < 1000; n++) begin
      v = 8'($urandom);
      r = ($urandom_range(31) == 0);
      step(v, r, "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
